// File: rtl/tmr_err_manager.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_err_manager
//  Purpose  : Error manager and resynchronisation sequencer for a bank of TMR
//             voters. Keeps a leaky saturating error counter per replica,
//             marks replicas permanently faulty, runs the halt/resync/resume
//             handshake with the core after each corrected error, and
//             escalates uncorrectable or multi-replica faults to sticky FATAL.
//  Ports    : clk_i, rst_ni          clock, async active-low reset
//             enable_i               gate for error inputs
//             err_detected_{1,2,3}_i per-voter replica disagreement flags
//             err_corrected_i        per-voter corrected-majority flags
//             err_detected_i         per-voter any-mismatch flags
//             halt_ack_i             core halt acknowledge (level)
//             clear_i                clears counters, faulty, fatal, FSM
//             halt_o, resync_o       core control
//             faulty_o, fatal_o      sticky fault status
//             busy_o                 sequencer not idle
//             err_cnt_o              replica k at [k*CNT_W +: CNT_W]
//  Revision : 1.0 - initial release
// ============================================================================
module tmr_err_manager #(
  parameter int N_ERR      = 5,
  parameter int CNT_W      = 4,
  parameter int PERM_TH    = 8,
  parameter int DECAY_PER  = 1024,
  parameter int RESYNC_CYC = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic [N_ERR-1:0]   err_detected_1_i,
  input  logic [N_ERR-1:0]   err_detected_2_i,
  input  logic [N_ERR-1:0]   err_detected_3_i,
  input  logic [N_ERR-1:0]   err_corrected_i,
  input  logic [N_ERR-1:0]   err_detected_i,
  input  logic               halt_ack_i,
  input  logic               clear_i,
  output logic               halt_o,
  output logic               resync_o,
  output logic [2:0]         faulty_o,
  output logic               fatal_o,
  output logic               busy_o,
  output logic [3*CNT_W-1:0] err_cnt_o
);

  localparam int IDLE_W = (DECAY_PER > 1) ? $clog2(DECAY_PER) : 1;
  localparam int RC_W   = (RESYNC_CYC > 1) ? $clog2(RESYNC_CYC) : 1;

  localparam logic [IDLE_W-1:0] c_IDLE_LAST = IDLE_W'((DECAY_PER > 0) ? DECAY_PER - 1 : 0);
  localparam logic [RC_W-1:0]   c_RC_LAST   = RC_W'(RESYNC_CYC - 1);
  localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  c_PERM_TH   = CNT_W'(PERM_TH);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_HALT   = 3'd1;
  localparam logic [2:0] c_ST_RESYNC = 3'd2;
  localparam logic [2:0] c_ST_RESUME = 3'd3;
  localparam logic [2:0] c_ST_FATAL  = 3'd4;

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  logic [2:0] w_rep_err;
  logic       w_corr, w_uncorr, w_event, w_quiet, w_decay;
  logic [2:0] w_faulty;
  logic       w_fatal;

  assign w_rep_err[0] = enable_i & (|err_detected_1_i);
  assign w_rep_err[1] = enable_i & (|err_detected_2_i);
  assign w_rep_err[2] = enable_i & (|err_detected_3_i);
  assign w_corr       = enable_i & (|err_corrected_i);
  assign w_uncorr     = enable_i & (|(err_detected_i & ~err_corrected_i));
  assign w_event      = w_corr | (|w_rep_err);
  assign w_quiet      = ~(|w_rep_err);

  // --------------------------------------------------------------------------
  // Idle counter: decay fires on the DECAY_PER-th consecutive quiet cycle
  // --------------------------------------------------------------------------
  logic [IDLE_W-1:0] idle_q, idle_d;

  assign w_decay = (DECAY_PER != 0) && w_quiet && (idle_q == c_IDLE_LAST);

  always_comb begin
    idle_d = idle_q;
    if (clear_i || !w_quiet || w_decay) begin
      idle_d = '0;
    end else if (DECAY_PER != 0) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idle_q <= '0;
    else         idle_q <= idle_d;
  end

  // --------------------------------------------------------------------------
  // Per-replica leaky counters and sticky faulty flags
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < 3; k++) begin : g_rep
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             faulty_q, faulty_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (w_rep_err[k]) begin
        if (cnt_q != c_CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else if (w_decay && (cnt_q != '0)) begin
        cnt_d = cnt_q - 1'b1;
      end
      // Threshold is judged on the next count so the flag rises with it.
      faulty_d = clear_i ? 1'b0 : (faulty_q | (cnt_d >= c_PERM_TH));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q    <= '0;
        faulty_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        faulty_q <= faulty_d;
      end
    end

    assign err_cnt_o[k*CNT_W +: CNT_W] = cnt_q;
    assign w_faulty[k]                 = faulty_q;
  end

  assign faulty_o = w_faulty;

  // Two faulty replicas leave no trustworthy majority.
  assign w_fatal = w_uncorr |
                   (w_faulty[0] & w_faulty[1]) |
                   (w_faulty[0] & w_faulty[2]) |
                   (w_faulty[1] & w_faulty[2]);

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  logic [2:0]      state_q, state_d;
  logic            pend_q, pend_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;
  logic            halt_d, resync_d, fatal_d, busy_d;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    rcnt_d  = rcnt_q;
    if (clear_i) begin
      state_d = c_ST_IDLE;
      pend_d  = 1'b0;
      rcnt_d  = '0;
    end else if (w_fatal) begin
      state_d = c_ST_FATAL;
      pend_d  = 1'b0;
    end else begin
      // Errors during a sequence are remembered, never restart it.
      if ((state_q inside {c_ST_HALT, c_ST_RESYNC, c_ST_RESUME}) && w_event) begin
        pend_d = 1'b1;
      end
      case (state_q)
        c_ST_IDLE: begin
          if (w_event) state_d = c_ST_HALT;
        end
        c_ST_HALT: begin
          if (halt_ack_i) begin
            state_d = c_ST_RESYNC;
            rcnt_d  = '0;
          end
        end
        c_ST_RESYNC: begin
          if (rcnt_q == c_RC_LAST) state_d = c_ST_RESUME;
          else                     rcnt_d  = rcnt_q + 1'b1;
        end
        c_ST_RESUME: begin
          if (!halt_ack_i) begin
            // An error arriving on the exit cycle itself also counts as pending.
            if (pend_q || w_event) begin
              state_d = c_ST_HALT;
              pend_d  = 1'b0;
            end else begin
              state_d = c_ST_IDLE;
            end
          end
        end
        c_ST_FATAL: begin
          state_d = c_ST_FATAL;
        end
        default: begin
          state_d = c_ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register with it.
  assign halt_d   = (state_d inside {c_ST_HALT, c_ST_RESYNC, c_ST_FATAL});
  assign resync_d = (state_d == c_ST_RESYNC);
  assign fatal_d  = (state_d == c_ST_FATAL);
  assign busy_d   = (state_d != c_ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= c_ST_IDLE;
      pend_q   <= 1'b0;
      rcnt_q   <= '0;
      halt_o   <= 1'b0;
      resync_o <= 1'b0;
      fatal_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      rcnt_q   <= rcnt_d;
      halt_o   <= halt_d;
      resync_o <= resync_d;
      fatal_o  <= fatal_d;
      busy_o   <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tmr_err_manager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmr_err_manager
//  Purpose  : Directed, scoreboard-checked bench for tmr_err_manager
//             (PERM_TH=8, DECAY_PER=16, RESYNC_CYC=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_err_manager;

  localparam int N_ERR = 5;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, enable, ack_man, ack_follow, clear;
  logic [N_ERR-1:0]   ed1, ed2, ed3, ecorr, edet;
  logic               halt_ack;
  logic               halt, resync, fatal, busy;
  logic [2:0]         faulty;
  logic [3*CNT_W-1:0] cnt;

  // The core model either echoes halt_o or is driven by hand.
  assign halt_ack = ack_follow ? halt : ack_man;

  tmr_err_manager #(
    .N_ERR      (N_ERR),
    .CNT_W      (CNT_W),
    .PERM_TH    (8),
    .DECAY_PER  (16),
    .RESYNC_CYC (4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .enable_i         (enable),
    .err_detected_1_i (ed1),
    .err_detected_2_i (ed2),
    .err_detected_3_i (ed3),
    .err_corrected_i  (ecorr),
    .err_detected_i   (edet),
    .halt_ack_i       (halt_ack),
    .clear_i          (clear),
    .halt_o           (halt),
    .resync_o         (resync),
    .faulty_o         (faulty),
    .fatal_o          (fatal),
    .busy_o           (busy),
    .err_cnt_o        (cnt)
  );

  typedef struct {
    int               cyc;
    string            tag;
    bit               chk_fsm;
    bit               halt;
    bit               resync;
    bit               fatal;
    bit               busy;
    bit [2:0]         faulty;
    bit [3*CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_err    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due by this cycle and compares.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      bit   ok;
      e  = sb.pop_front();
      ok = (fatal == e.fatal) && (faulty == e.faulty) && (cnt == e.cnt);
      if (e.chk_fsm) begin
        ok = ok && (halt == e.halt) && (resync == e.resync) && (busy == e.busy);
      end
      n_checks++;
      if (!ok) begin
        n_err++;
        $display("FAIL %s: got halt=%0b resync=%0b fatal=%0b busy=%0b faulty=%b cnt=%h, want halt=%0b resync=%0b fatal=%0b busy=%0b faulty=%b cnt=%h (fsm fields %s)",
                 e.tag, halt, resync, fatal, busy, faulty, cnt,
                 e.halt, e.resync, e.fatal, e.busy, e.faulty, e.cnt,
                 e.chk_fsm ? "checked" : "ignored");
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic quiet();
    ed1 = '0; ed2 = '0; ed3 = '0; ecorr = '0; edet = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic expect_now(input string tag, input bit chk_fsm,
                            input bit h, input bit r, input bit f, input bit b,
                            input bit [2:0] fl,
                            input bit [CNT_W-1:0] c0, input bit [CNT_W-1:0] c1,
                            input bit [CNT_W-1:0] c2);
    exp_t e;
    e.cyc = cyc; e.tag = tag; e.chk_fsm = chk_fsm;
    e.halt = h; e.resync = r; e.fatal = f; e.busy = b;
    e.faulty = fl; e.cnt = {c2, c1, c0};
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; ack_man = 1'b0; ack_follow = 1'b0; clear = 1'b0;
    quiet();
    tick(2);
    expect_now("reset", 1, 0,0,0,0, 3'b000, 0,0,0);
    n_checks++;
    if ({halt, resync, fatal, busy, faulty, cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_direct: got halt=%0b resync=%0b fatal=%0b busy=%0b faulty=%b cnt=%h, want all 0",
               halt, resync, fatal, busy, faulty, cnt);
    end
    rst_n = 1'b1;
    tick();

    // Single corrected error on replica 2, ack returned two cycles later.
    ed2 = 5'b00100; ecorr = 5'b00100; edet = 5'b00100;
    tick(); quiet();
    expect_now("t1_halt",      1, 1,0,0,1, 3'b000, 0,1,0);
    tick();
    expect_now("t1_wait_ack",  1, 1,0,0,1, 3'b000, 0,1,0);
    ack_man = 1'b1;
    tick();
    expect_now("t1_rs_first",  1, 1,1,0,1, 3'b000, 0,1,0);
    tick(3);
    expect_now("t1_rs_last",   1, 1,1,0,1, 3'b000, 0,1,0);
    tick();
    expect_now("t1_resume",    1, 0,0,0,1, 3'b000, 0,1,0);
    ack_man = 1'b0;
    tick();
    expect_now("t1_idle",      1, 0,0,0,0, 3'b000, 0,1,0);
    do_clear();
    expect_now("t1_clear",     1, 0,0,0,0, 3'b000, 0,0,0);
    n_checks++;
    if ({halt, resync, fatal, busy, faulty, cnt} !== '0) begin
      n_err++;
      $display("FAIL t1_clear_direct: got halt=%0b resync=%0b fatal=%0b busy=%0b faulty=%b cnt=%h, want all 0",
               halt, resync, fatal, busy, faulty, cnt);
    end

    // Threshold and saturation on replica 3, then one decay step.
    ack_follow = 1'b1;
    ed3 = 5'b00001; ecorr = 5'b00001; edet = 5'b00001;
    tick(7);
    expect_now("t2_below_th",  0, 0,0,0,0, 3'b000, 0,0,7);
    tick();
    expect_now("t2_perm",      0, 0,0,0,0, 3'b100, 0,0,8);
    tick(7);
    expect_now("t2_sat",       0, 0,0,0,0, 3'b100, 0,0,15);
    tick();
    expect_now("t2_sat_hold",  0, 0,0,0,0, 3'b100, 0,0,15);
    quiet();
    tick(16);
    expect_now("t2_decay_kept",0, 0,0,0,0, 3'b100, 0,0,14);
    ack_follow = 1'b0;
    do_clear();
    expect_now("t2_clear",     1, 0,0,0,0, 3'b000, 0,0,0);

    // Decay of replica 1 from 3 to 0 over 48 quiet cycles, no underflow.
    ack_follow = 1'b1;
    ed1 = 5'b00010; ecorr = 5'b00010; edet = 5'b00010;
    tick(3); quiet();
    expect_now("t3_cnt3",      0, 0,0,0,0, 3'b000, 3,0,0);
    tick(15);
    expect_now("t3_pre_decay", 0, 0,0,0,0, 3'b000, 3,0,0);
    tick();
    expect_now("t3_decay1",    0, 0,0,0,0, 3'b000, 2,0,0);
    tick(32);
    expect_now("t3_zero",      1, 0,0,0,0, 3'b000, 0,0,0);
    tick(16);
    expect_now("t3_floor",     1, 0,0,0,0, 3'b000, 0,0,0);
    ack_follow = 1'b0;

    // Uncorrectable error while in RESYNC.
    ed2 = 5'b00100; ecorr = 5'b00100; edet = 5'b00100;
    tick(); quiet();
    ack_man = 1'b1;
    tick();
    expect_now("t4_resync",    1, 1,1,0,1, 3'b000, 0,1,0);
    edet = 5'b00001;
    tick(); edet = '0;
    expect_now("t4_fatal",     1, 1,0,1,1, 3'b000, 0,1,0);
    n_checks++;
    if (fatal !== 1'b1 || halt !== 1'b1 || resync !== 1'b0) begin
      n_err++;
      $display("FAIL t4_fatal_direct: got fatal=%0b halt=%0b resync=%0b, want fatal=1 halt=1 resync=0",
               fatal, halt, resync);
    end
    tick(2);
    expect_now("t4_sticky",    1, 1,0,1,1, 3'b000, 0,1,0);
    ack_man = 1'b0;
    do_clear();
    expect_now("t4_clear",     1, 0,0,0,0, 3'b000, 0,0,0);

    // Pending corrected error during RESYNC gives exactly one re-halt.
    ecorr = 5'b00010; edet = 5'b00010;
    tick(); quiet();
    expect_now("t5_halt",      1, 1,0,0,1, 3'b000, 0,0,0);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    ecorr = 5'b00010; edet = 5'b00010;
    tick(); quiet();
    tick(3);
    expect_now("t5_resume",    1, 0,0,0,1, 3'b000, 0,0,0);
    tick();
    expect_now("t5_rehalt",    1, 1,0,0,1, 3'b000, 0,0,0);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    tick(4);
    expect_now("t5_resume2",   1, 0,0,0,1, 3'b000, 0,0,0);
    tick();
    expect_now("t5_idle",      1, 0,0,0,0, 3'b000, 0,0,0);
    tick(3);
    expect_now("t5_stay_idle", 1, 0,0,0,0, 3'b000, 0,0,0);

    // Two replicas reach the threshold together: fatal one cycle later.
    ack_follow = 1'b1;
    ed1 = 5'b00001; ed2 = 5'b00001; ecorr = 5'b00001; edet = 5'b00001;
    tick(8); quiet();
    expect_now("t6_two_faulty",0, 0,0,0,0, 3'b011, 8,8,0);
    tick();
    expect_now("t6_fatal",     1, 1,0,1,1, 3'b011, 8,8,0);
    ack_follow = 1'b0;
    do_clear();
    expect_now("t6_clear",     1, 0,0,0,0, 3'b000, 0,0,0);

    // Inputs ignored while disabled, including an uncorrectable pattern.
    enable = 1'b0;
    ed1 = 5'b00001; ecorr = 5'b00001; edet = 5'b00011;
    tick(2); quiet();
    enable = 1'b1;
    expect_now("t7_disabled",  1, 0,0,0,0, 3'b000, 0,0,0);

    // Asynchronous reset while in HALT.
    ed2 = 5'b00100; ecorr = 5'b00100; edet = 5'b00100;
    tick(); quiet();
    expect_now("t8_halt",      1, 1,0,0,1, 3'b000, 0,1,0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    expect_now("t8_async_rst", 1, 0,0,0,0, 3'b000, 0,0,0);
    #1;
    n_checks++;
    if ({halt, resync, fatal, busy, faulty, cnt} !== '0) begin
      n_err++;
      $display("FAIL t8_async_direct: got halt=%0b resync=%0b fatal=%0b busy=%0b faulty=%b cnt=%h, want all 0",
               halt, resync, fatal, busy, faulty, cnt);
    end
    tick();
    rst_n = 1'b1;
    tick(2);
    expect_now("t8_after_rst", 1, 0,0,0,0, 3'b000, 0,0,0);

    // clear_i together with a new error mid-sequence.
    ed1 = 5'b00010; ecorr = 5'b00010; edet = 5'b00010;
    tick();
    expect_now("t9_halt",      1, 1,0,0,1, 3'b000, 1,0,0);
    clear = 1'b1;
    tick();
    clear = 1'b0; quiet();
    expect_now("t9_clear_wins",1, 0,0,0,0, 3'b000, 0,0,0);
    n_checks++;
    if ({halt, resync, fatal, busy, faulty, cnt} !== '0) begin
      n_err++;
      $display("FAIL t9_clear_direct: got halt=%0b resync=%0b fatal=%0b busy=%0b faulty=%b cnt=%h, want all 0",
               halt, resync, fatal, busy, faulty, cnt);
    end
    tick(3);
    expect_now("t9_no_pend",   1, 0,0,0,0, 3'b000, 0,0,0);

    @(negedge clk);
    @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_err++;
      $display("FAIL %s: expectation never compared, got none, want comparison at cycle %0d", e.tag, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
